muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M execute unit beside the single-cycle ALU in the EX stage.
//  Performs MUL/MULH/MULHSU/MULHU (MUL_STAGES-cycle multiply) and DIV/DIVU/REM/REMU (radix-2 restoring, 1 bit/cycle).
//  Valid/ready on both sides; one operation in flight; hazard unit stalls on busy, squashes on flush.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, even)
//  MUL_STAGES  2   multiply latency in cycles, accept to out_valid (1..4)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-high reset
//  flush      in   1     synchronous squash of in-flight op (pipeline redirect)
//  in_valid   in   1     operation request
//  in_ready   out  1     unit can accept (state IDLE)
//  op         in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  operand_1  in   XLEN  rs1 value
//  operand_2  in   XLEN  rs2 value
//  out_valid  out  1     result available
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result, stable while out_valid && !out_ready
//  zero       out  1     result == 0, qualified by out_valid
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counters=0.
//  Accept = in_valid && in_ready; op/operands latched on that edge, never sampled later.
//  FSM: IDLE -> MUL | DIV | DONE(special div) ; MUL -> DONE after MUL_STAGES-1 cycles;
//       DIV -> DONE after XLEN iterations + 1 sign-fixup cycle; DONE -> IDLE on out_ready.
//  Latency (accept edge to first out_valid cycle): MUL* = MUL_STAGES; DIV* = XLEN+2; special div = 1.
//  Multiply: 2*XLEN product of sign-extended (MULH: s*s, MULHSU: s*u, MULHU: u*u) operands;
//   MUL returns low XLEN bits, others high XLEN bits.
//  Divide: magnitudes divided unsigned; quotient negated iff signs differ (DIV); remainder takes dividend sign (REM).
//  Special cases, decided at accept, bypass iteration (1-cycle):
//   divisor==0: DIV/DIVU = all-ones, REM/REMU = operand_1.
//   DIV/REM with operand_1=-2^(XLEN-1), operand_2=-1: DIV = operand_1, REM = 0.
//  DONE: out_valid=1, result/zero held until out_ready; in_ready=0, so no back-to-back overlap.
//   out_valid && out_ready -> IDLE next edge, in_ready=1 next cycle (1 bubble).
//  flush: any state -> IDLE next edge; out_valid=0, result dropped, no out_valid for it ever.
//   flush && in_valid in IDLE: request ignored (flush wins).
//  in_valid while busy: ignored, no side effects; requester must hold.
//  reset mid-operation: immediate IDLE, outputs to reset values; op lost.
//  result updates only on entry to DONE; zero = (result==0) combinationally.
// TESTING
//  1. MUL 7*-3 (XLEN=32) -> out_valid 2 cycles after accept, result=0xFFFFFFEB, zero=0.
//  2. MULH/MULHSU/MULHU 0x80000000*0xFFFFFFFF -> 0x00000000 / 0x80000000 / 0x7FFFFFFF.
//  3. DIV -20/3 -> 34 cycles, result 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 20/3 -> 6.
//  4. DIVU x/0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000/-1 -> 0, zero=1; DIV same -> 0x80000000.
//  5. out_ready=0 for 5 cycles in DONE -> result stable; in_valid ignored; in_ready=1 after release.
//  6. flush at DIV iteration 10, and reset mid-MUL -> IDLE, no out_valid; next DIVU 9/2 -> 4.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle RV32M execute unit sitting beside the single-cycle ALU.
//   Multiplies (MUL/MULH/MULHSU/MULHU) complete MUL_STAGES cycles after
//   accept. Divides (DIV/DIVU/REM/REMU) use a radix-2 restoring divider,
//   one quotient bit per cycle, plus one sign-fixup cycle. Divide-by-zero
//   and signed overflow are resolved at accept and finish in one cycle.
//   One operation in flight. The result is held until the consumer takes it.
//
// Ports
//   clk        in   1     clock, rising edge
//   reset      in   1     asynchronous, active-high reset
//   flush      in   1     synchronous squash of the in-flight op
//   in_valid   in   1     operation request
//   in_ready   out  1     unit can accept (idle)
//   op         in   3     funct3 of the M-extension instruction
//   operand_1  in   XLEN  rs1 value
//   operand_2  in   XLEN  rs2 value
//   out_valid  out  1     result available
//   out_ready  in   1     consumer takes the result
//   result     out  XLEN  result, stable while out_valid && !out_ready
//   zero       out  1     result == 0, gated by out_valid
//   busy       out  1     unit is not idle
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   MUL_LAST   = CW'(MUL_STAGES > 1 ? MUL_STAGES - 2 : 0);
    localparam logic [CW-1:0]   DIV_LAST   = CW'(XLEN);
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_op;        // op[1:0]; op[2] is implied by the state
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;       // partial remainder
    logic [XLEN-1:0] r_quo;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0] r_dvs;       // divisor magnitude
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    // Product of the operands sign-extended as the op demands. MUL takes the
    // low half, which does not depend on the extension.
    function automatic logic [XLEN-1:0] mul_calc(input logic [1:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic            sa;
        logic            sb;
        logic [2*XLEN-1:0] ea;
        logic [2*XLEN-1:0] eb;
        logic [2*XLEN-1:0] p;
        sa = (f == 2'b01) || (f == 2'b10);
        sb = (f == 2'b01);
        ea = {{XLEN{sa & a[XLEN-1]}}, a};
        eb = {{XLEN{sb & b[XLEN-1]}}, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // ---------------- accept-time decode ----------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    // flush wins over a simultaneous request
    assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
    assign w_is_div   = op[2];
    assign w_div_zero = (operand_2 == '0);
    assign w_div_ovf  = !op[0] && (operand_1 == SIGNED_MIN) && (operand_2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;
    // op[1] selects REM/REMU over DIV/DIVU
    assign w_special_res = w_div_zero ? (op[1] ? operand_1 : '1)
                                      : (op[1] ? '0 : operand_1);

    // op[0]==0 marks the signed divides (DIV, REM)
    assign w_a_neg = !op[0] && operand_1[XLEN-1];
    assign w_b_neg = !op[0] && operand_2[XLEN-1];
    assign w_a_mag = w_a_neg ? -operand_1 : operand_1;
    assign w_b_mag = w_b_neg ? -operand_2 : operand_2;

    // ---------------- restoring divide step ----------------
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    // The shifted remainder is below 2*divisor, so one extra bit holds the sign.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = !w_diff[XLEN];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a value unassigned and infers a latch.
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    if (w_is_div)
                        w_next = w_special ? S_DONE : S_DIV;
                    else
                        w_next = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                end
            end
            S_MUL: if (r_cnt == MUL_LAST) w_next = S_DONE;
            S_DIV: if (r_cnt == DIV_LAST) w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op[1:0];
                        r_a     <= operand_1;
                        r_b     <= operand_2;
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_cnt   <= '0;
                        if (w_is_div && w_special)
                            r_result <= w_special_res;
                        else if (!w_is_div && MUL_STAGES == 1)
                            r_result <= mul_calc(op[1:0], operand_1, operand_2);
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_next == S_DONE)
                        r_result <= mul_calc(r_op, r_a, r_b);
                end
                S_DIV: begin
                    if (r_cnt != DIV_LAST) begin
                        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!flush) begin
                        // sign-fixup cycle
                        if (r_op[1])
                            r_result <= r_neg_r ? -r_rem : r_rem;
                        else
                            r_result <= r_neg_q ? -r_quo : r_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign zero   = out_valid && (r_result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_1;
    logic [XLEN-1:0] operand_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        string           tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; it is accepted on the next posedge.
    task automatic send(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat, input string tag);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        op        = f;
        operand_1 = a;
        operand_2 = b;
        in_valid  = 1'b1;
        exp_q.push_back('{exp, lat, tag});
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " bubble out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " bubble in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Called at the first negedge after accept (cycle 1 of the latency count).
    task automatic receive(input bit release_now);
        exp_t e;
        int   cyc = 1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: observed empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({e.tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({e.tag, " latency"},   32'(cyc), 32'(e.lat));
        check({e.tag, " result"},    result, e.res);
        check({e.tag, " zero"},      32'(zero), 32'(e.res == '0));
        if (release_now) release_result(e.tag);
    endtask

    task automatic run(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int lat, input string tag);
        send(f, a, b, exp, lat, tag);
        receive(1'b1);
    endtask

    initial begin
        logic seen;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) @(negedge clk);
        check("reset in_ready",  32'(in_ready),  32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset result",    result,         32'd0);
        reset = 1'b0;
        @(negedge clk);

        // multiply
        run(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, "mul 7*-3");
        run(OP_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, "mulh");
        run(OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "mulhsu");
        run(OP_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 2, "mulhu");
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "mulhu max");
        run(OP_MUL,    32'h00012345, 32'h00010000, 32'h23450000, 2, "mul wrap");

        // divide
        run(OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 34, "div -20/3");
        run(OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 34, "rem -20/3");
        run(OP_DIVU,   32'd20,       32'd3,        32'd6,        34, "divu 20/3");
        run(OP_REMU,   32'd20,       32'd3,        32'd2,        34, "remu 20/3");
        run(OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 34, "div 20/-3");
        run(OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        34, "rem 20/-3");
        run(OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34, "divu max/1");
        run(OP_REMU,   32'd21,       32'd7,        32'd0,        34, "remu exact");

        // special divides
        run(OP_DIVU,   32'd1234,     32'd0,        32'hFFFFFFFF, 1, "divu x/0");
        run(OP_DIV,    32'hFFFFFF00, 32'd0,        32'hFFFFFFFF, 1, "div x/0");
        run(OP_REMU,   32'd5,        32'd0,        32'd5,        1, "remu 5/0");
        run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, "rem ovf");
        run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div ovf");
        run(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34, "divu no ovf");

        // backpressure in DONE
        send(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu hold");
        receive(1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            op        = OP_MUL;
            operand_1 = $urandom;
            operand_2 = $urandom;
            @(negedge clk);
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold result",    result,         32'd14);
            check("hold in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        release_result("divu hold");
        repeat (3) @(negedge clk);
        check("after hold busy",      32'(busy),      32'd0);
        check("after hold out_valid", 32'(out_valid), 32'd0);

        // flush at divide iteration 10
        op        = OP_DIV;
        operand_1 = 32'hFFFFFF9C;
        operand_2 = 32'd7;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        check("flush busy before", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy",      32'(busy),      32'd0);
        check("flush in_ready",  32'(in_ready),  32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush no out_valid", 32'(seen), 32'd0);

        // flush beats a simultaneous request
        op        = OP_MUL;
        operand_1 = 32'd3;
        operand_2 = 32'd4;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b0;
        check("flush+req busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush+req no out_valid", 32'(seen), 32'd0);

        // reset mid-multiply
        op        = OP_MUL;
        operand_1 = 32'd9;
        operand_2 = 32'd9;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        check("mid-mul busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async reset busy",      32'(busy),      32'd0);
        check("async reset in_ready",  32'(in_ready),  32'd1);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset result",    result,         32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("reset no out_valid", 32'(seen), 32'd0);

        run(OP_DIVU, 32'd9, 32'd2, 32'd4, 34, "divu 9/2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
